i2c_target: RTL and testbench

I2C target (slave) for the IR_repositioning design; it is the responder side of the `i2c` controller's bus. It decodes a 7-bit address and supports pointer-based register writes and auto-incrementing reads over a simple synchronous register port. The block runs on the system clock, oversamples SCL/SDA, and drives SDA open-drain. It serves as the on-board peripheral model, including the IR camera emulation used in controller benches.

---
 rtl/i2c_target.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target with a 7-bit address, an 8-bit register pointer, pointer-based writes
// and auto-incrementing reads over a synchronous register port. SDA is open-drain.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h58
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RACK      = 4'd8,
    S_WAIT_STOP = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        reg_we_q, reg_we_d;
  logic        busy_q, busy_d;
  logic        rw_q, rw_d;
  logic        ack_seen_q, ack_seen_d;
  logic        inc_pend_q, inc_pend_d;
  logic [1:0]  scl_s_q, scl_s_d;
  logic [1:0]  sda_s_q, sda_s_d;
  logic        scl_p_q, scl_p_d;
  logic        sda_p_q, sda_p_d;

  logic        scl_rise, scl_fall, start_det, stop_det, do_load;
  logic [7:0]  rx_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      ack_seen_q  <= 1'b0;
      inc_pend_q  <= 1'b0;
      scl_s_q     <= 2'b11;
      sda_s_q     <= 2'b11;
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      ack_seen_q  <= ack_seen_d;
      inc_pend_q  <= inc_pend_d;
      scl_s_q     <= scl_s_d;
      sda_s_q     <= sda_s_d;
      scl_p_q     <= scl_p_d;
      sda_p_q     <= sda_p_d;
    end
  end

  // Bus events come from the synchronized pins compared with their previous value.
  assign scl_rise  = scl_s_q[1] & ~scl_p_q;
  assign scl_fall  = ~scl_s_q[1] & scl_p_q;
  assign start_det = scl_s_q[1] & scl_p_q & sda_p_q & ~sda_s_q[1];
  assign stop_det  = scl_s_q[1] & scl_p_q & ~sda_p_q & sda_s_q[1];
  assign rx_byte   = {shift_q[6:0], sda_s_q[1]};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    busy_d      = busy_q;
    rw_d        = rw_q;
    ack_seen_d  = ack_seen_q;
    inc_pend_d  = 1'b0;
    do_load     = 1'b0;
    scl_s_d     = {scl_s_q[0], SCL};
    sda_s_d     = {sda_s_q[0], SDA};
    scl_p_d     = scl_s_q[1];
    sda_p_d     = sda_s_q[1];

    if (inc_pend_q) reg_addr_d = reg_addr_q + 8'd1;

    if (start_det) begin
      state_d    = S_ADDR;
      bit_cnt_d  = 4'd0;
      sda_oe_d   = 1'b0;
      ack_seen_d = 1'b0;
    end else if (stop_det) begin
      state_d    = S_IDLE;
      bit_cnt_d  = 4'd0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      ack_seen_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == S_ADDR) begin
                rw_d = rx_byte[0];
                if (rx_byte[7:1] == ADDR) begin
                  state_d = S_ADDR_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = S_WAIT_STOP;
                end
              end else if (state_q == S_PTR) begin
                reg_addr_d = rx_byte;
                state_d    = S_PTR_ACK;
              end else begin
                reg_wdata_d = rx_byte;
                reg_we_d    = 1'b1;
                inc_pend_d  = 1'b1;
                state_d     = S_WDATA_ACK;
              end
            end
          end
        end
        // First SCL fall starts driving the ACK, the second one ends it.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              if (state_q == S_ADDR_ACK && rw_q) do_load = 1'b1;
              else if (state_q == S_ADDR_ACK)    state_d = S_PTR;
              else                               state_d = S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d   = 1'b0;
              bit_cnt_d  = 4'd0;
              ack_seen_d = 1'b0;
              state_d    = S_RACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        S_RACK: begin
          if (scl_rise) begin
            if (!sda_s_q[1]) begin
              ack_seen_d = 1'b1;
            end else begin
              state_d = S_WAIT_STOP;
              busy_d  = 1'b0;
            end
          end else if (scl_fall && ack_seen_q) begin
            do_load = 1'b1;
          end
        end
        S_IDLE, S_WAIT_STOP: ;
        default: state_d = S_IDLE;
      endcase

      if (do_load) begin
        shift_d    = reg_rdata;
        sda_oe_d   = ~reg_rdata[7];
        reg_addr_d = reg_addr_q + 8'd1;
        bit_cnt_d  = 4'd0;
        ack_seen_d = 1'b0;
        state_d    = S_RDATA;
      end
    end
  end

  // Register port: reg_we is a one-clk strobe qualifying reg_wdata at reg_addr;
  // there is no back-pressure, reg_rdata must follow reg_addr within one clk.
  always_comb begin
    reg_addr  = reg_addr_q;
    reg_wdata = reg_wdata_q;
    reg_we    = reg_we_q;
    busy      = busy_q;
    dbg_state = state_q;
  end

  assign SDA = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C controller tasks, an XOR-keyed register
// memory, and a pointer/queue reference model of the expected writes and reads.
module tb_i2c_target;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       tb_sda_low;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata, rd_key;
  logic       reg_we, busy;
  logic [3:0] dbg_state;

  int total = 0;
  int bad = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  pullup (sda_bus);
  assign sda_bus   = tb_sda_low ? 1'b0 : 1'bz;
  assign reg_rdata = reg_addr ^ rd_key;

  i2c_target dut (
    .clk(clk), .rst(rst), .SCL(scl), .SDA(sda_bus),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reg_we) got_q.push_back({reg_addr, reg_wdata});

  initial begin
    #800us;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    tb_sda_low = 1'b0; step(Q);
    scl = 1'b1;        step(Q);
    tb_sda_low = 1'b1; step(Q);
    scl = 1'b0;        step(Q);
  endtask

  task automatic bus_stop();
    tb_sda_low = 1'b1; step(Q);
    scl = 1'b1;        step(Q);
    tb_sda_low = 1'b0; step(Q);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    tb_sda_low = ~b; step(Q);
    scl = 1'b1;      step(Q);
    s = sda_bus;     step(Q);
    scl = 1'b0;      step(Q);
  endtask

  // ack output is the bus level on the 9th clock: 0 means acknowledged.
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    bus_bit(nack, s);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; tb_sda_low = 1'b0; rd_key = 8'h00;
    step(3);
    rst = 1'b0;
    step(4);
    total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b exp=1", sda_bus); end
    total++; if (reg_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", reg_addr); end
    total++; if (reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", reg_wdata); end
    total++; if (reg_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", reg_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (dbg_state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_write_burst();
    logic [7:0] bytes [4];
    logic ack;
    logic [15:0] g;
    bytes = '{8'hB0, 8'h30, 8'h01, 8'h08};
    got_q.delete(); exp_q.delete();
    exp_q.push_back({8'h30, 8'h01});
    exp_q.push_back({8'h31, 8'h08});
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], ack);
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL wr_ack%0d got=%b exp=0", i, ack); end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_on got=%b exp=1", busy); end
    bus_stop();
    step(6);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_off got=%b exp=0", busy); end
    total++; if (reg_addr !== 8'h32) begin bad++; $display("FAIL wr_ptr got=%h exp=32", reg_addr); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL wr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      total++; if (g !== exp_q[i]) begin bad++; $display("FAIL wr_item%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_read_rs();
    logic ack;
    logic [7:0] b;
    logic [7:0] exp_b;
    got_q.delete();
    rd_key = 8'hA5;
    bus_start();
    send_byte(8'hB0, ack);
    send_byte(8'h36, ack);
    bus_start();
    send_byte(8'hB1, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
    for (int i = 0; i < 3; i++) begin
      recv_byte(i == 2, b);
      exp_b = (8'h36 + 8'(i)) ^ 8'hA5;
      total++; if (b !== exp_b) begin bad++; $display("FAIL rd_byte%0d got=%h exp=%h", i, b, exp_b); end
    end
    step(2);
    total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL rd_nack_release got=%b exp=1", sda_bus); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_nack_busy got=%b exp=0", busy); end
    bus_stop();
    step(4);
    total++; if (reg_addr !== 8'h39) begin bad++; $display("FAIL rd_ptr got=%h exp=39", reg_addr); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rd_no_write got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    got_q.delete();
    bus_start();
    send_byte(8'hA0, a0);
    send_byte(8'h12, a1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mm_busy got=%b exp=0", busy); end
    bus_stop();
    step(4);
    total++; if (a0 !== 1'b1) begin bad++; $display("FAIL mm_addr_nack got=%b exp=1", a0); end
    total++; if (a1 !== 1'b1) begin bad++; $display("FAIL mm_data_nack got=%b exp=1", a1); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL mm_no_write got=%0d exp=0", got_q.size()); end
    bus_start();
    send_byte(8'hB0, a0);
    total++; if (a0 !== 1'b0) begin bad++; $display("FAIL mm_next_ack got=%b exp=0", a0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mm_next_busy got=%b exp=1", busy); end
    bus_stop();
    step(4);
  endtask

  task automatic test_wrap();
    logic ack;
    logic [15:0] g;
    got_q.delete(); exp_q.delete();
    exp_q.push_back({8'hFF, 8'h11});
    exp_q.push_back({8'h00, 8'h22});
    bus_start();
    send_byte(8'hB0, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    bus_stop();
    step(4);
    total++; if (reg_addr !== 8'h01) begin bad++; $display("FAIL wrap_ptr got=%h exp=01", reg_addr); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
      total++; if (g !== exp_q[i]) begin bad++; $display("FAIL wrap_item%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    logic ack, s;
    got_q.delete();
    bus_start();
    send_byte(8'hB0, ack);
    send_byte(8'h5C, ack);
    bus_bit(1'b1, s); bus_bit(1'b0, s); bus_bit(1'b1, s); bus_bit(1'b1, s);
    bus_stop();
    step(6);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL abort_no_write got=%0d exp=0", got_q.size()); end
    total++; if (dbg_state !== 4'd0) begin bad++; $display("FAIL abort_idle got=%0d exp=0", dbg_state); end
    total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL abort_sda got=%b exp=1", sda_bus); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (reg_addr !== 8'h5C) begin bad++; $display("FAIL abort_ptr got=%h exp=5c", reg_addr); end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    got_q.delete();
    rd_key = 8'hA5;
    bus_start();
    send_byte(8'hB0, ack);
    send_byte(8'h80, ack);
    bus_start();
    send_byte(8'hB1, ack);
    // first read byte is 0x80^0xA5 = 0x25, so the target now drives a 0
    total++; if (sda_bus !== 1'b0) begin bad++; $display("FAIL rmr_drive got=%b exp=0", sda_bus); end
    rst = 1'b1;
    step(2);
    total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL rmr_release got=%b exp=1", sda_bus); end
    rst = 1'b0;
    step(1);
    total++; if (reg_addr !== 8'h00) begin bad++; $display("FAIL rmr_addr got=%h exp=00", reg_addr); end
    total++; if (reg_wdata !== 8'h00) begin bad++; $display("FAIL rmr_wdata got=%h exp=00", reg_wdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmr_busy got=%b exp=0", busy); end
    total++; if (dbg_state !== 4'd0) begin bad++; $display("FAIL rmr_state got=%0d exp=0", dbg_state); end
    send_byte(8'hB0, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL rmr_ignored got=%b exp=1", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmr_ignored_busy got=%b exp=0", busy); end
    bus_start();
    send_byte(8'hB0, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rmr_restart_ack got=%b exp=0", ack); end
    send_byte(8'h44, ack);
    bus_stop();
    step(4);
    total++; if (reg_addr !== 8'h44) begin bad++; $display("FAIL rmr_ptr got=%h exp=44", reg_addr); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rmr_no_write got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_random();
    logic ack;
    logic [7:0] p, d, b, exp_b, bad_addr;
    logic [15:0] g;
    int n;
    for (int r = 0; r < 6; r++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      got_q.delete(); exp_q.delete();
      bus_start();
      send_byte(8'hB0, ack);
      send_byte(p, ack);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        exp_q.push_back({8'((int'(p) + i) % 256), d});
        send_byte(d, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rnd%0d_wack%0d got=%b exp=0", r, i, ack); end
      end
      bus_stop();
      step(4);
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_wcount got=%0d exp=%0d", r, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
        total++; if (g !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_witem%0d got=%h exp=%h", r, i, g, exp_q[i]); end
      end
      total++; if (reg_addr !== 8'((int'(p) + n) % 256)) begin bad++; $display("FAIL rnd%0d_wptr got=%h", r, reg_addr); end

      rd_key = 8'($urandom);
      got_q.delete();
      bus_start();
      send_byte(8'hB0, ack);
      send_byte(p, ack);
      bus_start();
      send_byte(8'hB1, ack);
      for (int i = 0; i < n; i++) begin
        recv_byte(i == n - 1, b);
        exp_b = 8'((int'(p) + i) % 256) ^ rd_key;
        total++; if (b !== exp_b) begin bad++; $display("FAIL rnd%0d_rbyte%0d got=%h exp=%h", r, i, b, exp_b); end
      end
      bus_stop();
      step(4);
      total++; if (reg_addr !== 8'((int'(p) + n) % 256)) begin bad++; $display("FAIL rnd%0d_rptr got=%h", r, reg_addr); end
      total++; if (got_q.size() != 0) begin bad++; $display("FAIL rnd%0d_rnowrite got=%0d exp=0", r, got_q.size()); end

      bad_addr = 8'($urandom_range(0, 127));
      if (bad_addr[6:0] == 7'h58) bad_addr = 8'h59;
      bus_start();
      send_byte({bad_addr[6:0], 1'($urandom)}, ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL rnd%0d_foreign got=%b exp=1", r, ack); end
      bus_stop();
      step(4);
    end
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; tb_sda_low = 1'b0; rd_key = 8'h00;
    test_reset();
    test_write_burst();
    test_read_rs();
    test_mismatch();
    test_wrap();
    test_abort();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
